bc_clr_skid_buffer: RTL and testbench
=====================================

# bc_clr_skid_buffer

Two-entry valid/ready skid buffer with a synchronous clear, feeding a downstream clear/enable register stage. Breaks the combinational ready path between producer and consumer: `oReady` is registered, and full throughput is kept at one transfer per cycle. `iClr` flushes in-flight data in the same cycle as a downstream register clear, so the buffer and the downstream stage restart together.

## Interface
- `WIDTH`, 32, data width of `iDat`/`oDat`
- `INI_DATA`, `'0`, value of `oDat` and the skid register after reset or clear
- `CNT_WIDTH`, 16, width of the transfer counter `oCnt`

Ports:
- `clk`  in  1  clock; one clock domain only
- `rst`  in  1  reset, synchronous, active-high
- `iClr`  in  1  synchronous flush
- `iValid`  in  1  upstream data valid
- `oReady`  out  1  upstream ready (registered)
- `iDat`  in  WIDTH  upstream data
- `oValid`  out  1  downstream data valid
- `iReady`  in  1  downstream ready
- `oDat`  out  WIDTH  downstream data (registered)
- `oCnt`  out  CNT_WIDTH  count of downstream transfers

## Operation
- Transfer definitions:
  - `in` = `iValid & oReady & !iClr`
  - `out` = `oValid & iReady & !iClr`
- State machine:
  - EMPTY: `oValid`=0, `oReady`=1
  - BUSY: main register full, `oValid`=1, `oReady`=1
  - FULL: main and skid registers full, `oValid`=1, `oReady`=0
- Transitions:
  - EMPTY: `in` -> BUSY, main <= `iDat`.
  - BUSY:
    - `in & out` -> BUSY, main <= `iDat`.
    - `in & !out` -> FULL, skid <= `iDat`.
    - `!in & out` -> EMPTY.
    - Otherwise hold.
  - FULL: `out` -> BUSY, main <= skid. Otherwise hold. No input is accepted in FULL.
- `oValid` and `oReady` decode directly from state flops, with no combinational path from `iValid` or `iReady`.
- `oDat` holds its value while `oValid & !iReady`. Upstream data is never dropped or duplicated.
- `iClr` has priority over everything except `rst`:
  - state -> EMPTY
  - main and skid <= `INI_DATA`
  - both handshakes in that cycle are void; data is discarded and not counted
  - `oCnt` is not cleared
- `rst`: same as `iClr`, and additionally `oCnt` <= 0.
- `oCnt` increments by 1 on each `out` and wraps from 2^CNT_WIDTH-1 to 0.

## Timing
- Reset values: `oValid`=0, `oReady`=1, `oDat`=`INI_DATA`, `oCnt`=0, state EMPTY.
- Latency: a word accepted in cycle N is presented on `oDat` with `oValid`=1 in cycle N+1.
- Throughput: 1 word/cycle sustained while `iReady`=1.
- `iReady` low for one cycle in BUSY with `in`: `oReady` goes low the next cycle. The word in flight lands in skid, so there is no loss.
- `iClr` asserted mid-stream: `oValid`=0 the following cycle, and `oReady`=1 the following cycle.
- `rst` and `iClr` together: `rst` semantics apply.

## Configuration
- `ZION_BC_SKID_CNT_EN`:
  - Defined: the `oCnt` counter is built as described.
  - Undefined: no counter flops; `oCnt` is tied to 0. The port remains, so instantiations are unchanged.

## Structure
- Shared package `zion_bc_skid_pkg`: state enum typedef (EMPTY/BUSY/FULL, 2-bit encoding).
- Main and skid data registers use the library's `BcClrEnRapDff` macro with `INI_DATA`.
- No new sub-module. Control FSM and counter are local to this block.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles -> `oValid`=0, `oReady`=1, `oDat`=`INI_DATA`, `oCnt`=0.
2. **Streaming:** `iValid`=1 with `iDat`=1,2,3,… and `iReady`=1 -> `oDat` shows 1,2,3,… one cycle later. `oReady` stays 1, and `oCnt`=8 after 8 words.
3. **Backpressure:** send 0xA, 0xB back-to-back with `iReady`=0 -> `oReady`=0 after 0xB is accepted and `oDat`=0xA holds. Then `iReady`=1 -> 0xA, then 0xB, in order; `oReady` returns to 1.
4. **Clear while FULL:** `iClr`=1 for one cycle -> next cycle `oValid`=0, `oDat`=`INI_DATA`, `oReady`=1, and `oCnt` unchanged.
5. **Counter wrap:** `CNT_WIDTH`=4, 17 transfers -> `oCnt`=1.
6. **Random soak:** random `iValid`/`iReady`/`iClr` for 10k cycles against a FIFO scoreboard -> no loss, duplication or reordering except the words discarded by `iClr`.

Source files
------------

// File: rtl/zion_bc_skid_pkg.sv
//------------------------------------------------------------------------------
// Module   : zion_bc_skid_pkg
// Purpose  : Shared types for the clear-capable valid/ready skid buffer.
//            Holds the control state encoding used by bc_clr_skid_buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package zion_bc_skid_pkg;

  // Buffer occupancy state: nothing held, main register held, main + skid held
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skidState_t;

endpackage

`default_nettype wire

// File: rtl/bc_clr_skid_buffer.sv
//------------------------------------------------------------------------------
// Module   : bc_clr_skid_buffer
// Purpose  : Two-entry valid/ready skid buffer with synchronous clear. oReady
//            and oValid come straight from flops, so there is no combinational
//            path between iValid/iReady and the handshake outputs, while one
//            transfer per cycle is still sustained.
// Ports    : clk    - clock
//            rst    - synchronous active-high reset (also zeroes oCnt)
//            iClr   - synchronous flush; voids both handshakes this cycle
//            iValid - upstream valid       oReady - upstream ready (registered)
//            iDat   - upstream data        oDat   - downstream data (registered)
//            oValid - downstream valid     iReady - downstream ready
//            oCnt   - downstream transfer count (wraps)
// Config   : ZION_BC_SKID_CNT_EN - when defined the transfer counter is built;
//            otherwise oCnt is tied to zero and no counter flops exist.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Clear/enable data register: reset or clear loads the initial value,
// otherwise the register loads d when en is high.
`ifndef BcClrEnRapDff
`define BcClrEnRapDff(q, d, clr, en, ini) \
  always_ff @(posedge clk) begin \
    if (rst || (clr)) q <= (ini); \
    else if (en) q <= (d); \
  end
`endif

module bc_clr_skid_buffer
  import zion_bc_skid_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INI_DATA  = '0,
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iClr,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [WIDTH-1:0]     iDat,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [WIDTH-1:0]     oDat,
  output logic [CNT_WIDTH-1:0] oCnt
);

  skidState_t       r_state;
  logic             r_oValid;
  logic             r_oReady;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic             w_in;
  logic             w_out;
  logic             w_mainEn;
  logic [WIDTH-1:0] w_mainD;
  logic             w_skidEn;

  // A clear voids both handshakes in the cycle it is asserted
  assign w_in  = iValid & r_oReady & ~iClr;
  assign w_out = r_oValid & iReady & ~iClr;

  // Main register loads fresh input when it is (or is becoming) the head,
  // and refills from skid when the head drains while FULL.
  always_comb begin
    w_mainEn = 1'b0;
    w_mainD  = iDat;
    w_skidEn = 1'b0;
    case (r_state)
      ST_EMPTY: w_mainEn = w_in;
      ST_BUSY: begin
        w_mainEn = w_in & w_out;
        w_skidEn = w_in & ~w_out;
      end
      ST_FULL: begin
        w_mainEn = w_out;
        w_mainD  = r_skid;
      end
      default: begin
        w_mainEn = 1'b0;
        w_skidEn = 1'b0;
      end
    endcase
  end

  `BcClrEnRapDff(r_main, w_mainD, iClr, w_mainEn, INI_DATA)
  `BcClrEnRapDff(r_skid, iDat,    iClr, w_skidEn, INI_DATA)

  // Control FSM with handshake outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst || iClr) begin
      r_state  <= ST_EMPTY;
      r_oValid <= 1'b0;
      r_oReady <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            r_state  <= ST_BUSY;
            r_oValid <= 1'b1;
            r_oReady <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in && !w_out) begin
            r_state  <= ST_FULL;
            r_oValid <= 1'b1;
            r_oReady <= 1'b0;
          end else if (!w_in && w_out) begin
            r_state  <= ST_EMPTY;
            r_oValid <= 1'b0;
            r_oReady <= 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out) begin
            r_state  <= ST_BUSY;
            r_oValid <= 1'b1;
            r_oReady <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_EMPTY;
          r_oValid <= 1'b0;
          r_oReady <= 1'b1;
        end
      endcase
    end
  end

  assign oValid = r_oValid;
  assign oReady = r_oReady;
  assign oDat   = r_main;

`ifdef ZION_BC_SKID_CNT_EN
  // Counter survives iClr; only rst zeroes it
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign oCnt = r_cnt;
`else
  assign oCnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bc_clr_skid_buffer.sv
`default_nettype none

module tb_bc_clr_skid_buffer;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] INI       = 32'hDEAD_BEEF;
  localparam int          CNT_WIDTH = 4;
`ifdef ZION_BC_SKID_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iClr;
  logic                 iValid;
  logic                 oReady;
  logic [WIDTH-1:0]     iDat;
  logic                 oValid;
  logic                 iReady;
  logic [WIDTH-1:0]     oDat;
  logic [CNT_WIDTH-1:0] oCnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO of held words, last presented data, transfer count
  logic [WIDTH-1:0]     q[$];
  logic [WIDTH-1:0]     expDat;
  logic [CNT_WIDTH-1:0] cntM;

  bc_clr_skid_buffer #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .iClr  (iClr),
    .iValid(iValid),
    .oReady(oReady),
    .iDat  (iDat),
    .oValid(oValid),
    .iReady(iReady),
    .oDat  (oDat),
    .oCnt  (oCnt)
  );

  always #5 clk = ~clk;

  function automatic logic expValid();
    return q.size() > 0;
  endfunction

  function automatic logic expReady();
    return q.size() < 2;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] expCnt();
    return CNT_EN ? cntM : '0;
  endfunction

  // Advance one clock and update the model from the inputs held this cycle
  task automatic tick();
    bit mIn;
    bit mOut;
    mIn  = iValid && (q.size() < 2) && !iClr;
    mOut = (q.size() > 0) && iReady && !iClr;
    @(posedge clk);
    if (rst || iClr) begin
      q.delete();
      expDat = INI;
      if (rst) cntM = '0;
    end else begin
      if (mOut) begin
        void'(q.pop_front());
        cntM = cntM + 1'b1;
      end
      if (mIn) q.push_back(iDat);
      if (q.size() > 0) expDat = q[0];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0; iDat = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_oValid got=%b exp=0", oValid); end
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL reset_oReady got=%b exp=1", oReady); end
    checks++; if (oDat !== INI) begin failures++; $display("FAIL reset_oDat got=%h exp=%h", oDat, INI); end
    checks++; if (oCnt !== 4'd0) begin failures++; $display("FAIL reset_oCnt got=%0d exp=0", oCnt); end
  endtask

  task automatic test_streaming();
    iReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iValid = 1'b1; iDat = 32'(i);
      tick();
      checks++;
      if (oValid !== 1'b1 || oDat !== 32'(i) || oReady !== 1'b1) begin
        failures++;
        $display("FAIL stream_word%0d got v=%b r=%b d=%h exp v=1 r=1 d=%h", i, oValid, oReady, oDat, i);
      end
    end
    iValid = 1'b0;
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", oValid); end
    checks++;
    if (oCnt !== (CNT_EN ? 4'd8 : 4'd0)) begin
      failures++; $display("FAIL stream_cnt got=%0d exp=%0d", oCnt, CNT_EN ? 8 : 0);
    end
  endtask

  task automatic test_backpressure();
    iReady = 1'b0;
    iValid = 1'b1; iDat = 32'hA; tick();
    iDat = 32'hB; tick();
    iValid = 1'b0; iDat = 32'hC;
    checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", oReady); end
    checks++; if (oDat !== 32'hA || oValid !== 1'b1) begin failures++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=a", oValid, oDat); end
    iValid = 1'b1; tick(); // offered while FULL: must be refused
    iValid = 1'b0;
    checks++; if (oDat !== 32'hA || oReady !== 1'b0) begin failures++; $display("FAIL bp_hold2 got r=%b d=%h exp r=0 d=a", oReady, oDat); end
    iReady = 1'b1; tick();
    checks++; if (oDat !== 32'hB || oValid !== 1'b1) begin failures++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=b", oValid, oDat); end
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", oReady); end
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0 (refused word leaked)", oValid); end
  endtask

  task automatic test_clear_full();
    logic [CNT_WIDTH-1:0] cntBefore;
    iReady = 1'b0;
    iValid = 1'b1; iDat = 32'h11; tick();
    iDat = 32'h22; tick();
    cntBefore = expCnt();
    iClr = 1'b1; iReady = 1'b1; iValid = 1'b1; iDat = 32'h33;
    tick();
    iClr = 1'b0; iValid = 1'b0;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL clr_oValid got=%b exp=0", oValid); end
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL clr_oReady got=%b exp=1", oReady); end
    checks++; if (oDat !== INI) begin failures++; $display("FAIL clr_oDat got=%h exp=%h", oDat, INI); end
    checks++; if (oCnt !== cntBefore) begin failures++; $display("FAIL clr_oCnt got=%0d exp=%0d", oCnt, cntBefore); end
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL clr_void_in got=%b exp=0", oValid); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    iReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      iValid = 1'b1; iDat = 32'(100 + i); tick();
    end
    iValid = 1'b0; tick();
    checks++;
    if (oCnt !== (CNT_EN ? 4'd1 : 4'd0)) begin
      failures++; $display("FAIL wrap_cnt got=%0d exp=%0d", oCnt, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_rst_clr();
    iReady = 1'b0; iValid = 1'b1; iDat = 32'h55; tick();
    rst = 1'b1; iClr = 1'b1; tick();
    rst = 1'b0; iClr = 1'b0; iValid = 1'b0;
    checks++; if (oCnt !== 4'd0 || oValid !== 1'b0 || oDat !== INI) begin
      failures++; $display("FAIL rst_clr got cnt=%0d v=%b d=%h exp cnt=0 v=0 d=%h", oCnt, oValid, oDat, INI);
    end
  endtask

  task automatic test_soak();
    int bad = 0;
    for (int c = 0; c < 10000; c++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iReady = ($urandom_range(0, 2) != 0);
      iClr   = ($urandom_range(0, 40) == 0);
      iDat   = $urandom;
      checks++;
      if (oValid !== expValid() || oReady !== expReady() || oDat !== expDat || oCnt !== expCnt()) begin
        failures++;
        if (bad < 10) $display("FAIL soak_cycle%0d got v=%b r=%b d=%h c=%0d exp v=%b r=%b d=%h c=%0d",
                               c, oValid, oReady, oDat, oCnt, expValid(), expReady(), expDat, expCnt());
        bad++;
      end
      tick();
    end
    iClr = 1'b0; iValid = 1'b0;
  endtask

  initial begin
    cntM = '0; expDat = INI;
    test_reset();
    test_streaming();
    test_backpressure();
    test_clear_full();
    test_wrap();
    test_rst_clr();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
